// File: rtl/reg_array_pkg.sv
// rtl/reg_array_pkg.sv - shared state type, lane count and zero-word helpers for reg_array_dual
`timescale 1ns/1ps
package reg_array_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_t;

    localparam int MAX_WORD_W = 1024;

    function automatic int calc_lanes(input int width, input int lane_width);
        return width / lane_width;
    endfunction

    function automatic logic [MAX_WORD_W-1:0] zero_word();
        return '0;
    endfunction

endpackage

// File: rtl/reg_array_clr.sv
// rtl/reg_array_clr.sv - post-reset clear sequencer: walks every address once writing zero
`timescale 1ns/1ps
module reg_array_clr
    import reg_array_pkg::*;
#(
    parameter int depth     = 8192,
    parameter int add_width = 13
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 busy,
    output logic                 clr_we,
    output logic [add_width-1:0] clr_add
);

    localparam logic [add_width-1:0] LAST_ADD = add_width'(depth - 1);

    clr_state_t           r_state;
    clr_state_t           w_state_nxt;
    logic [add_width-1:0] r_cnt;
    logic [add_width-1:0] w_cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        busy        = 1'b0;
        clr_we      = 1'b0;
        clr_add     = r_cnt;
        case (r_state)
            CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
                // Leaving CLEAR on the edge that writes the last address drops busy there.
                if (r_cnt == LAST_ADD) begin
                    w_state_nxt = READY;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            READY: begin
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/reg_array_dual.sv
// rtl/reg_array_dual.sv - one-write/one-read masked register array; REG_ARRAY_BYPASS_EN selects write-first collisions
`timescale 1ns/1ps
module reg_array_dual
    import reg_array_pkg::*;
#(
    parameter int width      = 16,
    parameter int lane_width = 8,
    parameter int depth      = 8192,
    parameter int add_width  = 13
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    output logic                                     busy,
    input  logic                                     we,
    input  logic [add_width-1:0]                     wadd,
    input  logic [calc_lanes(width, lane_width)-1:0] wmask,
    input  logic [width-1:0]                         wr,
    input  logic                                     re,
    input  logic [add_width-1:0]                     radd,
    output logic [width-1:0]                         rd,
    output logic                                     rd_valid
);

    localparam int               LANES  = calc_lanes(width, lane_width);
    localparam logic [width-1:0] ZERO_W = width'(zero_word());

    logic [width-1:0]     r_mem [depth];
    logic [width-1:0]     r_rd;
    logic                 r_rd_valid;

    logic                 w_clr_we;
    logic [add_width-1:0] w_clr_add;
    logic                 w_wr_in_range;
    logic                 w_rd_in_range;
    logic                 w_user_we;
    logic                 w_mem_we;
    logic [add_width-1:0] w_mem_add;
    logic [LANES-1:0]     w_mem_mask;
    logic [width-1:0]     w_mem_data;
    logic [width-1:0]     w_old_word;
    logic [width-1:0]     w_rd_word;

    reg_array_clr #(
        .depth     (depth),
        .add_width (add_width)
    ) u_clr (
        .clk     (clk),
        .rst_n   (rst_n),
        .busy    (busy),
        .clr_we  (w_clr_we),
        .clr_add (w_clr_add)
    );

    assign w_wr_in_range = 32'(wadd) < depth;
    assign w_rd_in_range = 32'(radd) < depth;
    assign w_user_we     = ~busy & we & w_wr_in_range;

    // The clear sequencer owns the write port outright while busy.
    assign w_mem_we   = w_clr_we | (w_user_we & (|wmask));
    assign w_mem_add  = w_clr_we ? w_clr_add : wadd;
    assign w_mem_mask = w_clr_we ? {LANES{1'b1}} : wmask;
    assign w_mem_data = w_clr_we ? ZERO_W : wr;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < LANES; i++) begin
                if (w_mem_mask[i]) begin
                    r_mem[w_mem_add][i*lane_width +: lane_width] <= w_mem_data[i*lane_width +: lane_width];
                end
            end
        end
    end

    assign w_old_word = r_mem[radd];

    always_comb begin
        w_rd_word = w_old_word;
`ifdef REG_ARRAY_BYPASS_EN
        if (w_user_we && (wadd == radd)) begin
            for (int i = 0; i < LANES; i++) begin
                if (wmask[i]) begin
                    w_rd_word[i*lane_width +: lane_width] = wr[i*lane_width +: lane_width];
                end
            end
        end
`endif
        if (!w_rd_in_range) begin
            w_rd_word = ZERO_W;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd       <= ZERO_W;
            r_rd_valid <= 1'b0;
        end else if (busy) begin
            r_rd       <= ZERO_W;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= re;
            if (re) begin
                r_rd <= w_rd_word;
            end
        end
    end

    assign rd       = r_rd;
    assign rd_valid = r_rd_valid;

endmodule
